hanoi_tower_engine: RTL and testbench
=====================================

Name: hanoi_tower_engine

Overview:
- Parametrised, resettable successor to the three-peg Towers of Hanoi puzzle model. Supports P pegs, N discs and a selectable target peg.
- Accepts one move request per cycle through a valid strobe. Checks legality and reports the outcome with a registered accept/reject pulse and an error code.
- Keeps a saturating count of accepted moves and can lock the puzzle once it is solved.
- Serves as a formal-verification and model-checking workload, for example "done reachable in 2^N-1 moves" and "no larger disc ever sits on a smaller disc".

Parameters:
N, 5, number of discs (1..15); disc sizes are 1..N, and 0 means an empty slot.
P, 3, number of pegs (3..8).
W, 4, disc/height field width; must satisfy 2^W > N.
PW, 3, peg index width; must satisfy 2^PW >= P.
TARGET, 1, index of the peg that must hold all N discs for done.
MCW, 16, width of the move counter.
LOCK_ON_DONE, 1, when 1, all moves are rejected once done=1.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset; restores the initial configuration
move_valid  in  1  move request strobe, sampled on the rising edge
from  in  PW  source peg index
to  in  PW  destination peg index
q_peg  in  PW  query peg index (combinational read)
q_height  out  W  number of discs on q_peg; 0 if q_peg>=P
q_top  out  W  size of the top disc on q_peg; 0 if the peg is empty or q_peg>=P
move_ack  out  1  one-cycle pulse: previous-cycle request was legal and has been applied
move_nak  out  1  one-cycle pulse: previous-cycle request was rejected
err_code  out  3  reason for the last rejection; held until the next request
move_count  out  MCW  number of accepted moves, saturating
done  out  1  height[TARGET]==N

Behaviour:
- State:
  - stack[p][i], W bits, for p<P and i<N; i=0 is the bottom slot.
  - height[p], W bits.
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - stack[0][i]=N-i; all other stacks are 0.
  - height[0]=N; all other heights are 0.
  - move_ack=0, move_nak=0, err_code=0, move_count=0.
  - done=0, unless TARGET==0, in which case done=1.
- Legality is evaluated combinationally on the current state when move_valid=1. The first failing check, in this order, sets err_code:
  - 1: from>=P or to>=P.
  - 2: from==to.
  - 5: LOCK_ON_DONE=1 and done=1.
  - 3: height[from]==0.
  - 4: height[to]!=0 and top(from) > top(to). Equal sizes cannot occur.
- Legal move, applied on the clock edge at which the request is sampled:
  - stack[to][height[to]] <= top(from).
  - stack[from][height[from]-1] <= 0.
  - height[to]++, height[from]--.
  - move_ack=1 for exactly the following cycle; err_code <= 0.
  - move_count++ unless it is already all-ones, in which case it holds.
- Illegal move:
  - State and move_count are unchanged.
  - move_nak=1 for the following cycle; err_code <= code.
- move_valid=0: move_ack and move_nak are 0 next cycle; err_code holds.
- Latency: one request per cycle, with no stall. A request in cycle k is judged against state that already includes the move from cycle k-1, so back-to-back moves are legal.
- done is derived combinationally from the registered heights, so it rises in the cycle after the final accepted move.
- With LOCK_ON_DONE=0, moves after done are allowed and done may fall again.
- Invariants, to be checked as assertions:
  - Sum of heights == N.
  - Every stack is strictly decreasing from bottom to top.
  - Slots at index >= height are 0.
  - move_ack and move_nak are never both 1.

Test Plan:
1. N=3, P=3, TARGET=1. Apply the seven optimal moves back-to-back with no gaps: 0>1, 0>2, 1>2, 0>1, 2>0, 2>1, 0>1. Required: seven consecutive ack pulses; move_count=7; done=1 one cycle after the last move; q_peg=1 gives q_height=3 and q_top=1.
2. Illegal sequence from reset:
   - 1>2 -> nak, err=3.
   - 0>0 -> nak, err=2.
   - 0>5 -> nak, err=1.
   - 0>1, then 0>1 -> ack, then nak with err=4 (disc 2 onto disc 1).
   - Required: move_count=1 throughout the rejected requests.
3. From the solved state of test 1 with LOCK_ON_DONE=1, request 1>0. Required: nak, err=5, state unchanged. With LOCK_ON_DONE=0, the same request is acked and done falls to 0 on the next cycle.
4. N=4, P=4, TARGET=3. Apply a 9-move Frame-Stewart solution. Required: done=1 after move_count=9; pegs 0, 1 and 2 all show q_height=0.
5. Assert reset asynchronously between clock edges after 4 moves of test 1. Required: immediate return to the initial state (q_peg=0 gives q_height=3, q_top=1); move_count=0; ack and nak low; a 0>1 request on the next edge is accepted.
6. MCW=3, N=3. Apply 10 legal shuttle moves (for example 0>2, 2>0 repeated). Required: move_count saturates at 7 while the moves continue to be acked.

Source files
------------

// File: rtl/hanoi_tower_engine.sv
// Towers of Hanoi move engine: P pegs, N discs. Each cycle it judges one
// move request against the current peg state, then applies it (ack) or
// rejects it (nak). It also keeps a saturating count of accepted moves.
module hanoi_tower_engine #(
    parameter int unsigned N            = 5,
    parameter int unsigned P            = 3,
    parameter int unsigned W            = 4,
    parameter int unsigned PW           = 3,
    parameter int unsigned TARGET       = 1,
    parameter int unsigned MCW          = 16,
    parameter bit          LOCK_ON_DONE = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           move_valid,
    input  logic [PW-1:0]  from,
    input  logic [PW-1:0]  to,
    input  logic [PW-1:0]  q_peg,
    output logic [W-1:0]   q_height,
    output logic [W-1:0]   q_top,
    output logic           move_ack,
    output logic           move_nak,
    output logic [2:0]     err_code,
    output logic [MCW-1:0] move_count,
    output logic           done
);

    localparam logic [PW:0] PegCount = (PW+1)'(P);

    // Slot 0 is the bottom of each peg; 0 marks an empty slot.
    logic [W-1:0] stack_q  [P][N];
    logic [W-1:0] height_q [P];

    logic [W-1:0] h_from, t_from, h_to, t_to;
    logic [2:0]   code;
    logic         legal;

    assign done = (height_q[TARGET] == W'(N));

    // Look up height and top disc for the source, destination and query pegs.
    always_comb begin
        h_from   = '0;
        t_from   = '0;
        h_to     = '0;
        t_to     = '0;
        q_height = '0;
        q_top    = '0;
        for (int p = 0; p < P; p++) begin
            if (from == PW'(p)) begin
                h_from = height_q[p];
                for (int i = 0; i < N; i++) begin
                    if (height_q[p] == W'(i + 1)) t_from = stack_q[p][i];
                end
            end
            if (to == PW'(p)) begin
                h_to = height_q[p];
                for (int i = 0; i < N; i++) begin
                    if (height_q[p] == W'(i + 1)) t_to = stack_q[p][i];
                end
            end
            if (q_peg == PW'(p)) begin
                q_height = height_q[p];
                for (int i = 0; i < N; i++) begin
                    if (height_q[p] == W'(i + 1)) q_top = stack_q[p][i];
                end
            end
        end
    end

    // Legality checks; the first failing one supplies the error code.
    always_comb begin
        code = 3'd0;
        if (({1'b0, from} >= PegCount) || ({1'b0, to} >= PegCount)) begin
            code = 3'd1;
        end else if (from == to) begin
            code = 3'd2;
        end else if (LOCK_ON_DONE && done) begin
            code = 3'd5;
        end else if (h_from == '0) begin
            code = 3'd3;
        end else if ((h_to != '0) && (t_from > t_to)) begin
            code = 3'd4;
        end
        legal = (code == 3'd0);
    end

    // Peg state, response pulses, error code and move counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < P; p++) begin
                height_q[p] <= (p == 0) ? W'(N) : '0;
                for (int i = 0; i < N; i++) begin
                    stack_q[p][i] <= (p == 0) ? W'(N - i) : '0;
                end
            end
            move_ack   <= 1'b0;
            move_nak   <= 1'b0;
            err_code   <= 3'd0;
            move_count <= '0;
        end else begin
            move_ack <= move_valid && legal;
            move_nak <= move_valid && !legal;
            if (move_valid) begin
                err_code <= code;
                if (legal) begin
                    for (int p = 0; p < P; p++) begin
                        if (to == PW'(p)) height_q[p] <= height_q[p] + W'(1);
                        if (from == PW'(p)) height_q[p] <= height_q[p] - W'(1);
                        for (int i = 0; i < N; i++) begin
                            if ((to == PW'(p)) && (h_to == W'(i))) begin
                                stack_q[p][i] <= t_from;
                            end
                            if ((from == PW'(p)) && (h_from == W'(i + 1))) begin
                                stack_q[p][i] <= '0;
                            end
                        end
                    end
                    if (move_count != '1) move_count <= move_count + MCW'(1);
                end
            end
        end
    end

    // Structural invariants of the puzzle state.
    int   height_sum;
    logic order_ok;
    logic clear_ok;

    // Gather invariant terms over every peg.
    always_comb begin
        height_sum = 0;
        order_ok   = 1'b1;
        clear_ok   = 1'b1;
        for (int p = 0; p < P; p++) begin
            height_sum = height_sum + int'(height_q[p]);
            for (int i = 0; i < N; i++) begin
                if ((W'(i) >= height_q[p]) && (stack_q[p][i] != '0)) clear_ok = 1'b0;
            end
            for (int i = 1; i < N; i++) begin
                if ((W'(i) < height_q[p]) && (stack_q[p][i] >= stack_q[p][i-1])) begin
                    order_ok = 1'b0;
                end
            end
        end
    end

    // Check the invariants on every clock edge outside reset.
    always @(posedge clock) begin
        if (!reset) begin
            assert (height_sum == int'(N));
            assert (order_ok);
            assert (clear_ok);
            assert (!(move_ack && move_nak));
        end
    end

endmodule

// File: tb/tb_hanoi_tower_engine.sv
// Directed bench for hanoi_tower_engine. Four instances cover the configurations:
// a (N=3, lock on), b (N=3, no lock), c (N=4, P=4, TARGET=3) and d (MCW=3).
module tb_hanoi_tower_engine;

    logic       clock;
    logic       reset;
    logic       valid_ab, valid_c, valid_d;
    logic [2:0] from_s, to_s, q_peg;

    logic [3:0]  qh_a, qt_a, qh_b, qt_b, qh_c, qt_c, qh_d, qt_d;
    logic        ack_a, nak_a, ack_b, nak_b, ack_c, nak_c, ack_d, nak_d;
    logic [2:0]  err_a, err_b, err_c, err_d;
    logic [15:0] cnt_a, cnt_b, cnt_c;
    logic [2:0]  cnt_d;
    logic        done_a, done_b, done_c, done_d;

    int passed = 0;
    int total  = 0;
    int cur_sel = 0;

    hanoi_tower_engine #(.N(3), .P(3), .W(4), .PW(3), .TARGET(1), .MCW(16), .LOCK_ON_DONE(1'b1))
    dut_a (.clock(clock), .reset(reset), .move_valid(valid_ab), .from(from_s), .to(to_s),
           .q_peg(q_peg), .q_height(qh_a), .q_top(qt_a), .move_ack(ack_a), .move_nak(nak_a),
           .err_code(err_a), .move_count(cnt_a), .done(done_a));

    hanoi_tower_engine #(.N(3), .P(3), .W(4), .PW(3), .TARGET(1), .MCW(16), .LOCK_ON_DONE(1'b0))
    dut_b (.clock(clock), .reset(reset), .move_valid(valid_ab), .from(from_s), .to(to_s),
           .q_peg(q_peg), .q_height(qh_b), .q_top(qt_b), .move_ack(ack_b), .move_nak(nak_b),
           .err_code(err_b), .move_count(cnt_b), .done(done_b));

    hanoi_tower_engine #(.N(4), .P(4), .W(4), .PW(3), .TARGET(3), .MCW(16), .LOCK_ON_DONE(1'b1))
    dut_c (.clock(clock), .reset(reset), .move_valid(valid_c), .from(from_s), .to(to_s),
           .q_peg(q_peg), .q_height(qh_c), .q_top(qt_c), .move_ack(ack_c), .move_nak(nak_c),
           .err_code(err_c), .move_count(cnt_c), .done(done_c));

    hanoi_tower_engine #(.N(3), .P(3), .W(4), .PW(3), .TARGET(1), .MCW(3), .LOCK_ON_DONE(1'b1))
    dut_d (.clock(clock), .reset(reset), .move_valid(valid_d), .from(from_s), .to(to_s),
           .q_peg(q_peg), .q_height(qh_d), .q_top(qt_d), .move_ack(ack_d), .move_nak(nak_d),
           .err_code(err_d), .move_count(cnt_d), .done(done_d));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Outputs of the instance the current vector targets.
    logic cur_ack, cur_nak, cur_done;
    int   cur_err, cur_cnt;
    always_comb begin
        cur_ack = ack_a; cur_nak = nak_a; cur_done = done_a;
        cur_err = int'(err_a); cur_cnt = int'(cnt_a);
        case (cur_sel)
            1: begin cur_ack = ack_b; cur_nak = nak_b; cur_done = done_b;
                     cur_err = int'(err_b); cur_cnt = int'(cnt_b); end
            2: begin cur_ack = ack_c; cur_nak = nak_c; cur_done = done_c;
                     cur_err = int'(err_c); cur_cnt = int'(cnt_c); end
            3: begin cur_ack = ack_d; cur_nak = nak_d; cur_done = done_d;
                     cur_err = int'(err_d); cur_cnt = int'(cnt_d); end
            default: ;
        endcase
    end

    typedef struct {
        int sel;
        int f;
        int t;
        int ack;
        int nak;
        int err;
        int cnt;
        int dn;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int sel, int f, int t, int ack, int nak, int err, int cnt,
                                int dn);
        vec_t v;
        v.sel = sel; v.f = f; v.t = t; v.ack = ack; v.nak = nak;
        v.err = err; v.cnt = cnt; v.dn = dn;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Back-to-back: drive on a falling edge, check the response on the next one.
    task automatic run_vectors(input int lo, input int hi);
        @(negedge clock);
        for (int i = lo; i <= hi; i++) begin
            cur_sel  = vecs[i].sel;
            from_s   = 3'(vecs[i].f);
            to_s     = 3'(vecs[i].t);
            valid_ab = (vecs[i].sel <= 1);
            valid_c  = (vecs[i].sel == 2);
            valid_d  = (vecs[i].sel == 3);
            @(negedge clock);
            check($sformatf("v%0d ack", i),  int'(cur_ack),  vecs[i].ack);
            check($sformatf("v%0d nak", i),  int'(cur_nak),  vecs[i].nak);
            check($sformatf("v%0d err", i),  cur_err,        vecs[i].err);
            check($sformatf("v%0d cnt", i),  cur_cnt,        vecs[i].cnt);
            check($sformatf("v%0d done", i), int'(cur_done), vecs[i].dn);
        end
        valid_ab = 1'b0;
        valid_c  = 1'b0;
        valid_d  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    initial begin
        // Test 1: optimal 3-disc solution, idx 0..6
        add(0, 0, 1, 1, 0, 0, 1, 0); add(0, 0, 2, 1, 0, 0, 2, 0);
        add(0, 1, 2, 1, 0, 0, 3, 0); add(0, 0, 1, 1, 0, 0, 4, 0);
        add(0, 2, 0, 1, 0, 0, 5, 0); add(0, 2, 1, 1, 0, 0, 6, 0);
        add(0, 0, 1, 1, 0, 0, 7, 1);
        // Test 2: illegal requests, idx 7..11
        add(0, 1, 2, 0, 1, 3, 0, 0); add(0, 0, 0, 0, 1, 2, 0, 0);
        add(0, 0, 5, 0, 1, 1, 0, 0); add(0, 0, 1, 1, 0, 0, 1, 0);
        add(0, 0, 1, 0, 1, 4, 1, 0);
        // Test 5 follow-up after async reset, idx 12
        add(0, 0, 1, 1, 0, 0, 1, 0);
        // Test 4: 4 pegs / 4 discs Frame-Stewart, idx 13..21
        add(2, 0, 2, 1, 0, 0, 1, 0); add(2, 0, 1, 1, 0, 0, 2, 0);
        add(2, 2, 1, 1, 0, 0, 3, 0); add(2, 0, 2, 1, 0, 0, 4, 0);
        add(2, 0, 3, 1, 0, 0, 5, 0); add(2, 2, 3, 1, 0, 0, 6, 0);
        add(2, 1, 0, 1, 0, 0, 7, 0); add(2, 1, 3, 1, 0, 0, 8, 0);
        add(2, 0, 3, 1, 0, 0, 9, 1);
        // Test 6: shuttle on a 3-bit counter, idx 22..31
        for (int k = 1; k <= 10; k++) begin
            if (k % 2 == 1) add(3, 0, 2, 1, 0, 0, (k > 7) ? 7 : k, 0);
            else            add(3, 2, 0, 1, 0, 0, (k > 7) ? 7 : k, 0);
        end

        reset = 1'b1; valid_ab = 1'b0; valid_c = 1'b0; valid_d = 1'b0;
        from_s = '0; to_s = '0; q_peg = '0;
        #12;
        reset = 1'b0;

        // Reset state
        #1;
        check("rst qh_a", int'(qh_a), 3);
        check("rst qt_a", int'(qt_a), 1);
        check("rst ack_a", int'(ack_a), 0);
        check("rst nak_a", int'(nak_a), 0);
        check("rst err_a", int'(err_a), 0);
        check("rst cnt_a", int'(cnt_a), 0);
        check("rst done_a", int'(done_a), 0);
        check("rst qh_c", int'(qh_c), 4);
        check("rst done_c", int'(done_c), 0);

        // Test 1
        run_vectors(0, 6);
        q_peg = 3'd1; #1;
        check("t1 qh peg1", int'(qh_a), 3);
        check("t1 qt peg1", int'(qt_a), 1);
        check("t1 cnt_b", int'(cnt_b), 7);
        check("t1 done_b", int'(done_b), 1);
        q_peg = 3'd5; #1;
        check("qh peg>=P", int'(qh_a), 0);
        check("qt peg>=P", int'(qt_a), 0);

        // Test 3: request 1>0 in the solved state
        from_s = 3'd1; to_s = 3'd0; valid_ab = 1'b1;
        @(negedge clock);
        valid_ab = 1'b0;
        check("t3 nak_a", int'(nak_a), 1);
        check("t3 ack_a", int'(ack_a), 0);
        check("t3 err_a", int'(err_a), 5);
        check("t3 cnt_a", int'(cnt_a), 7);
        check("t3 done_a", int'(done_a), 1);
        check("t3 ack_b", int'(ack_b), 1);
        check("t3 cnt_b", int'(cnt_b), 8);
        check("t3 done_b", int'(done_b), 0);
        q_peg = 3'd1; #1;
        check("t3 qh_a peg1", int'(qh_a), 3);
        check("t3 qh_b peg1", int'(qh_b), 2);
        check("t3 qt_b peg1", int'(qt_b), 2);

        // Test 2
        do_reset();
        run_vectors(7, 11);
        @(negedge clock);
        check("idle ack_a", int'(ack_a), 0);
        check("idle nak_a", int'(nak_a), 0);
        check("idle err_a", int'(err_a), 4);

        // Test 5: asynchronous reset between clock edges after four moves
        do_reset();
        q_peg = 3'd0;
        run_vectors(0, 3);
        check("t5 pre ack_a", int'(ack_a), 1);
        #2;
        reset = 1'b1;
        #1;
        check("t5 qh_a", int'(qh_a), 3);
        check("t5 qt_a", int'(qt_a), 1);
        check("t5 cnt_a", int'(cnt_a), 0);
        check("t5 ack_a", int'(ack_a), 0);
        check("t5 nak_a", int'(nak_a), 0);
        #1;
        reset = 1'b0;
        run_vectors(12, 12);

        // Test 4
        run_vectors(13, 21);
        for (int p = 0; p < 3; p++) begin
            q_peg = 3'(p); #1;
            check($sformatf("t4 qh_c peg%0d", p), int'(qh_c), 0);
        end
        q_peg = 3'd3; #1;
        check("t4 qh_c peg3", int'(qh_c), 4);
        check("t4 qt_c peg3", int'(qt_c), 1);

        // Test 6
        run_vectors(22, 31);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
